// File: rtl/pipe_stage_buf_if.sv
// pipe_stage_buf_if
// Groups the upstream and downstream valid/ready handshake of one elastic
// pipeline-stage buffer, together with the squash (flush) control and the
// occupancy count.
//
// Signals:
//   flush     - synchronous squash of every held and incoming entry
//   in_valid  - upstream presents in_data
//   in_ready  - buffer can accept an entry (occupancy below DEPTH)
//   in_data   - upstream payload, WIDTH bits
//   out_valid - head entry is valid (occupancy non-zero)
//   out_ready - downstream consumes the head this cycle
//   out_data  - head entry, or the bubble value when empty
//   count     - current occupancy, $clog2(DEPTH+1) bits
//
// Modports:
//   master - the environment around the buffer (upstream and downstream)
//   slave  - the buffer itself
interface pipe_stage_buf_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] count;

  modport master (
    output flush,
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  count
  );

  modport slave (
    input  flush,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output count
  );

endinterface

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf
// Elastic pipeline-stage register: a DEPTH-entry circular buffer with a
// valid/ready handshake on both sides. A stalled downstream stage
// back-pressures upstream through in_ready instead of a global enable.
// The payload is opaque; each stage boundary packs its own fields into it.
//
// Ports:
//   CLK  - rising-edge clock
//   nRST - asynchronous, active-low reset (clears pointers and count)
//   bus  - pipe_stage_buf_if.slave: flush, in_valid/in_ready/in_data,
//          out_valid/out_ready/out_data, count
//
// Parameters:
//   WIDTH      - payload width in bits (>= 1)
//   DEPTH      - number of entries (>= 1); 1 is a half-throughput stage
//                register, 2 or more sustains one entry per cycle
//   RESET_DATA - bubble value shown on out_data while the buffer is empty
module pipe_stage_buf #(
  parameter int               WIDTH      = 32,
  parameter int               DEPTH      = 2,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input logic              CLK,
  input logic              nRST,
  pipe_stage_buf_if.slave  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;

  logic             w_inReady;
  logic             w_outValid;
  logic             w_push;
  logic             w_pop;
  logic [PTR_W-1:0] w_wrPtrNext;
  logic [PTR_W-1:0] w_rdPtrNext;

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  // Handshake flags come only from the registered count, so there is no
  // combinational path from out_ready to in_ready or from input to output.
  // Flush suppresses both the push and the pop of its own cycle.
  always_comb begin
    w_inReady   = (r_count < FULL_CNT);
    w_outValid  = (r_count != '0);
    w_push      = bus.in_valid & w_inReady & ~bus.flush;
    w_pop       = w_outValid & bus.out_ready & ~bus.flush;
    w_wrPtrNext = nextPtr(r_wrPtr);
    w_rdPtrNext = nextPtr(r_rdPtr);
  end

  // Pointer and occupancy state; flush returns the buffer to empty without
  // touching the storage array.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= w_wrPtrNext;
      end
      if (w_pop) begin
        r_rdPtr <= w_rdPtrNext;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Storage is never reset; the count alone decides which slots are live.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= bus.in_data;
    end
  end

  // Empty buffer presents the bubble so downstream sees a NOP.
  always_comb begin
    bus.in_ready  = w_inReady;
    bus.out_valid = w_outValid;
    bus.count     = r_count;
    bus.out_data  = w_outValid ? r_mem[r_rdPtr] : RESET_DATA;
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf
// Directed bench for pipe_stage_buf. Three instances share one clock and
// reset: DEPTH=2 (reset/bubble, streaming), DEPTH=3 with a non-zero bubble
// value (back-pressure, wrap-around, flush) and DEPTH=1 (half throughput).
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled at the same point, away from the active edge.
module tb_pipe_stage_buf;

  logic CLK;
  logic nRST;

  int nAsserts;
  int nFails;

  localparam logic [31:0] BUBBLE3 = 32'h0000_0013;

  pipe_stage_buf_if #(.WIDTH(32), .DEPTH(2)) bus2 ();
  pipe_stage_buf_if #(.WIDTH(32), .DEPTH(3)) bus3 ();
  pipe_stage_buf_if #(.WIDTH(32), .DEPTH(1)) bus1 ();

  pipe_stage_buf #(.WIDTH(32), .DEPTH(2), .RESET_DATA(32'h0)) dut2 (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus2)
  );

  pipe_stage_buf #(.WIDTH(32), .DEPTH(3), .RESET_DATA(BUBBLE3)) dut3 (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus3)
  );

  pipe_stage_buf #(.WIDTH(32), .DEPTH(1), .RESET_DATA(32'h0)) dut1 (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus1)
  );

  // Free-running clock, period 10.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one instance's inputs; sel picks the instance by its depth.
  task automatic applyStimulus(input int sel, input bit fl, input bit valid,
                               input logic [31:0] data, input bit ready);
    case (sel)
      1: begin
        bus1.flush = fl; bus1.in_valid = valid;
        bus1.in_data = data; bus1.out_ready = ready;
      end
      2: begin
        bus2.flush = fl; bus2.in_valid = valid;
        bus2.in_data = data; bus2.out_ready = ready;
      end
      default: begin
        bus3.flush = fl; bus3.in_valid = valid;
        bus3.in_data = data; bus3.out_ready = ready;
      end
    endcase
  endtask

  // One comparison: counts it and reports a mismatch through $error.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic waitCycle();
    @(posedge CLK);
    #1;
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nAsserts = 0;
    nFails   = 0;
    nRST     = 1'b0;
    applyStimulus(1, 0, 0, 32'h0, 0);
    applyStimulus(2, 0, 0, 32'h0, 0);
    applyStimulus(3, 0, 0, 32'h0, 0);

    // Reset state while nRST is held low.
    #3;
    checkOutput("rst_out_valid", bus2.out_valid, 0);
    checkOutput("rst_in_ready", bus2.in_ready, 1);
    checkOutput("rst_count", bus2.count, 0);
    checkOutput("rst_out_data", bus2.out_data, 32'h0);
    checkOutput("rst_out_data3", bus3.out_data, BUBBLE3);
    nRST = 1'b1;
    waitCycle();

    // Load one entry, then drop nRST mid-cycle: clears without a clock.
    applyStimulus(2, 0, 1, 32'hDEAD, 0);
    waitCycle();
    checkOutput("pre_rst_count", bus2.count, 1);
    checkOutput("pre_rst_data", bus2.out_data, 32'hDEAD);
    applyStimulus(2, 0, 0, 32'h0, 0);
    #3;
    nRST = 1'b0;
    #1;
    checkOutput("async_rst_valid", bus2.out_valid, 0);
    checkOutput("async_rst_ready", bus2.in_ready, 1);
    checkOutput("async_rst_count", bus2.count, 0);
    checkOutput("async_rst_data", bus2.out_data, 32'h0);
    #1;
    nRST = 1'b1;
    waitCycle();

    // Streaming through DEPTH=2: each value appears one edge after its push.
    $display("[TB] streaming, DEPTH=2");
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(2, 0, 1, 32'(k), 1);
      checkOutput("stream_in_ready", bus2.in_ready, 1);
      waitCycle();
      checkOutput("stream_out_valid", bus2.out_valid, 1);
      checkOutput("stream_out_data", bus2.out_data, 32'(k));
    end
    applyStimulus(2, 0, 0, 32'h0, 1);
    waitCycle();
    checkOutput("stream_drained_valid", bus2.out_valid, 0);
    checkOutput("stream_drained_count", bus2.count, 0);
    applyStimulus(2, 0, 0, 32'h0, 0);

    // Back-pressure on DEPTH=3: A,B,C accepted, D refused while full.
    $display("[TB] back-pressure, DEPTH=3");
    applyStimulus(3, 0, 1, 32'hA, 0);
    waitCycle();
    applyStimulus(3, 0, 1, 32'hB, 0);
    waitCycle();
    applyStimulus(3, 0, 1, 32'hC, 0);
    waitCycle();
    checkOutput("full_count", bus3.count, 3);
    checkOutput("full_in_ready", bus3.in_ready, 0);
    applyStimulus(3, 0, 1, 32'hD, 0);
    waitCycle();
    checkOutput("refused_count", bus3.count, 3);
    checkOutput("refused_in_ready", bus3.in_ready, 0);
    checkOutput("stall_head", bus3.out_data, 32'hA);
    applyStimulus(3, 0, 0, 32'h0, 1);
    checkOutput("pop_head_A", bus3.out_data, 32'hA);
    waitCycle();
    checkOutput("after_pop_in_ready", bus3.in_ready, 1);
    checkOutput("after_pop_count", bus3.count, 2);
    checkOutput("pop_head_B", bus3.out_data, 32'hB);
    waitCycle();
    checkOutput("pop_head_C", bus3.out_data, 32'hC);
    waitCycle();
    checkOutput("bp_empty_valid", bus3.out_valid, 0);
    checkOutput("bp_empty_bubble", bus3.out_data, BUBBLE3);

    // Wrap-around: 10 pushes interleaved with pops, occupancy 1..2.
    $display("[TB] wrap-around, DEPTH=3");
    applyStimulus(3, 0, 1, 32'h100, 0);
    waitCycle();
    checkOutput("wrap_count1", bus3.count, 1);
    applyStimulus(3, 0, 1, 32'h101, 0);
    waitCycle();
    checkOutput("wrap_count2", bus3.count, 2);
    checkOutput("wrap_head0", bus3.out_data, 32'h100);
    for (int i = 2; i <= 9; i++) begin
      applyStimulus(3, 0, 1, 32'h100 + 32'(i), 1);
      waitCycle();
      checkOutput("wrap_head", bus3.out_data, 32'h100 + 32'(i - 1));
      checkOutput("wrap_count", bus3.count, 2);
    end
    applyStimulus(3, 0, 0, 32'h0, 1);
    waitCycle();
    checkOutput("wrap_last", bus3.out_data, 32'h109);
    waitCycle();
    checkOutput("wrap_empty", bus3.out_valid, 0);

    // Flush with simultaneous push and pop at count=2.
    $display("[TB] flush, DEPTH=3");
    applyStimulus(3, 0, 1, 32'h51, 0);
    waitCycle();
    applyStimulus(3, 0, 1, 32'h52, 0);
    waitCycle();
    checkOutput("pre_flush_count", bus3.count, 2);
    applyStimulus(3, 1, 1, 32'hBAD, 1);
    checkOutput("flush_cycle_in_ready", bus3.in_ready, 1);
    checkOutput("flush_cycle_out_valid", bus3.out_valid, 1);
    waitCycle();
    checkOutput("flush_count", bus3.count, 0);
    checkOutput("flush_out_valid", bus3.out_valid, 0);
    checkOutput("flush_in_ready", bus3.in_ready, 1);
    checkOutput("flush_out_data", bus3.out_data, BUBBLE3);
    applyStimulus(3, 0, 0, 32'h0, 1);
    waitCycle();
    checkOutput("flush_X_dropped", bus3.out_valid, 0);
    applyStimulus(3, 0, 1, 32'h77, 0);
    waitCycle();
    checkOutput("post_flush_push", bus3.out_data, 32'h77);
    checkOutput("post_flush_count", bus3.count, 1);
    applyStimulus(3, 0, 0, 32'h0, 1);
    waitCycle();
    checkOutput("post_flush_drain", bus3.count, 0);
    applyStimulus(3, 0, 0, 32'h0, 0);

    // DEPTH=1: valid held high, one entry every two cycles.
    $display("[TB] half throughput, DEPTH=1");
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1, 0, 1, 32'h50 + 32'(k), 1);
      checkOutput("d1_in_ready_hi", bus1.in_ready, 1);
      waitCycle();
      checkOutput("d1_in_ready_lo", bus1.in_ready, 0);
      checkOutput("d1_out_valid", bus1.out_valid, 1);
      checkOutput("d1_out_data", bus1.out_data, 32'h50 + 32'(k));
      applyStimulus(1, 0, 1, 32'h50 + 32'(k + 1), 1);
      waitCycle();
      checkOutput("d1_popped_valid", bus1.out_valid, 0);
    end
    applyStimulus(1, 0, 0, 32'h0, 0);
    waitCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
